pwm_fader: RTL and testbench

Memory-mapped duty-ramp controller on the RIB bus, placed directly upstream of the SoC's 3-channel PWM generator. Firmware writes a per-channel target duty and step size. The block then moves each channel's live duty value toward its target by one step per millisecond tick, producing breathing and fade effects without CPU polling. The three duty outputs drive the PWM block's duty inputs, and a one-cycle done pulse per channel reports arrival at target.

---
 rtl/pwm_fader.sv | 108 ++++++++++
 tb/tb_pwm_fader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fader.sv
// pwm_fader: memory-mapped duty-ramp controller for a 3-channel PWM generator.
//   clk       system clock
//   rst       asynchronous active-low reset
//   we_i      bus write strobe (already decoded for this slave)
//   addr_i    bus address, only [7:0] decoded
//   data_i    bus write data
//   data_o    bus read data, combinational from addr_i
//   duty_o_N  live duty per channel (registered)
//   done_o    one-cycle pulse per channel when a tick step lands on target
module pwm_fader #(
    parameter int TICK_CYCLES = 50000,
    parameter int MAX_DUTY    = 999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic [9:0]  duty_o_1,
    output logic [9:0]  duty_o_2,
    output logic [9:0]  duty_o_3,
    output logic [2:0]  done_o
);
    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [9:0] MAX_D = 10'(MAX_DUTY);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    target_q [3];
    logic [9:0]    target_d [3];
    logic [9:0]    step_q [3];
    logic [9:0]    step_d [3];
    logic [9:0]    cur_q [3];
    logic [9:0]    cur_d [3];
    logic [10:0]   sum [3];
    logic [2:0]    en_q, en_d, done_q, done_d, busy;
    logic [7:0]    a;
    logic          tick, load;

    assign a    = addr_i[7:0];
    assign tick = cnt_q == CNT_LAST;
    assign busy = {en_q[2] && cur_q[2] != target_q[2],
                   en_q[1] && cur_q[1] != target_q[1],
                   en_q[0] && cur_q[0] != target_q[0]};

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        load  = we_i && a == 8'h20 && data_i[8];
        en_d  = (we_i && a == 8'h20) ? data_i[2:0] : en_q;
        for (int i = 0; i < 3; i++) begin
            target_d[i] = (we_i && a == 8'(4 * i))
                        ? ((data_i > 32'(MAX_DUTY)) ? MAX_D : data_i[9:0]) : target_q[i];
            step_d[i]   = (we_i && a == 8'(16 + 4 * i)) ? data_i[9:0] : step_q[i];
            // 11-bit sum so cur + step cannot wrap before the clamp
            sum[i]      = {1'b0, cur_q[i]} + {1'b0, step_q[i]};
            cur_d[i]    = cur_q[i];
            // the CTRL load takes priority over a coincident tick and never signals done
            if (load)
                cur_d[i] = target_q[i];
            else if (tick && busy[i])
                cur_d[i] = (step_q[i] == '0) ? target_q[i]
                         : (cur_q[i] < target_q[i])
                           ? ((sum[i] >= {1'b0, target_q[i]}) ? target_q[i] : sum[i][9:0])
                           : ((step_q[i] >= cur_q[i] - target_q[i]) ? target_q[i]
                                                                   : cur_q[i] - step_q[i]);
            done_d[i] = !load && tick && busy[i] && cur_d[i] == target_q[i];
        end
    end

    always_comb begin
        data_o = '0;
        for (int i = 0; i < 3; i++) begin
            if (a == 8'(4 * i))      data_o = {22'b0, target_q[i]};
            if (a == 8'(16 + 4 * i)) data_o = {22'b0, step_q[i]};
            if (a == 8'(48 + 4 * i)) data_o = {22'b0, cur_q[i]};
        end
        if (a == 8'h20) data_o = {29'b0, en_q};
        if (a == 8'h24) data_o = {29'b0, busy};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            en_q   <= '0;
            done_q <= '0;
            for (int i = 0; i < 3; i++) begin
                target_q[i] <= '0;
                step_q[i]   <= '0;
                cur_q[i]    <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            en_q   <= en_d;
            done_q <= done_d;
            for (int i = 0; i < 3; i++) begin
                target_q[i] <= target_d[i];
                step_q[i]   <= step_d[i];
                cur_q[i]    <= cur_d[i];
            end
        end
    end

    assign duty_o_1 = cur_q[0];
    assign duty_o_2 = cur_q[1];
    assign duty_o_3 = cur_q[2];
    assign done_o   = done_q;
endmodule

// File: tb/tb_pwm_fader.sv
// tb_pwm_fader: directed and randomized checks of pwm_fader against a behavioural model.
module tb_pwm_fader;
    localparam int TC  = 4;
    localparam int MAX = 999;

    logic        clk = 0;
    logic        rst = 0;
    logic        we_i = 0;
    logic [31:0] addr_i = 0;
    logic [31:0] data_i = 0;
    logic [31:0] data_o;
    logic [9:0]  duty_o_1, duty_o_2, duty_o_3;
    logic [2:0]  done_o;

    pwm_fader #(.TICK_CYCLES(TC), .MAX_DUTY(MAX)) dut (
        .clk(clk), .rst(rst), .we_i(we_i), .addr_i(addr_i), .data_i(data_i),
        .data_o(data_o), .duty_o_1(duty_o_1), .duty_o_2(duty_o_2),
        .duty_o_3(duty_o_3), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int       m_tgt [3];
    int       m_stp [3];
    int       m_cur [3];
    bit [2:0] m_en;
    bit [2:0] m_done;
    int       ncyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a);
        logic [31:0] r;
        r = 0;
        for (int i = 0; i < 3; i++) begin
            if (a == 8'(4 * i))      r = m_tgt[i];
            if (a == 8'(16 + 4 * i)) r = m_stp[i];
            if (a == 8'(48 + 4 * i)) r = m_cur[i];
        end
        if (a == 8'h20) r = {29'b0, m_en};
        if (a == 8'h24)
            for (int i = 0; i < 3; i++) r[i] = m_en[i] && (m_cur[i] != m_tgt[i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_tgt[i] = 0;
            m_stp[i] = 0;
            m_cur[i] = 0;
        end
        m_en   = 0;
        m_done = 0;
        ncyc   = 0;
    endtask

    // one clock edge of the spec: tick/load act on pre-edge registers, writes land afterwards
    task automatic model_step(input logic we, input logic [7:0] a, input logic [31:0] d);
        bit tick, load;
        tick = (ncyc % TC) == TC - 1;
        ncyc++;
        load = we && a == 8'h20 && d[8];
        for (int i = 0; i < 3; i++) begin
            m_done[i] = 0;
            if (load)
                m_cur[i] = m_tgt[i];
            else if (tick && m_en[i] && m_cur[i] != m_tgt[i]) begin
                if (m_stp[i] == 0)
                    m_cur[i] = m_tgt[i];
                else if (m_cur[i] < m_tgt[i])
                    m_cur[i] = (m_cur[i] + m_stp[i] > m_tgt[i]) ? m_tgt[i] : m_cur[i] + m_stp[i];
                else
                    m_cur[i] = (m_cur[i] - m_stp[i] < m_tgt[i]) ? m_tgt[i] : m_cur[i] - m_stp[i];
                m_done[i] = m_cur[i] == m_tgt[i];
            end
        end
        if (we) begin
            for (int i = 0; i < 3; i++) begin
                if (a == 8'(4 * i))      m_tgt[i] = (d > MAX) ? MAX : int'(d[9:0]);
                if (a == 8'(16 + 4 * i)) m_stp[i] = int'(d[9:0]);
            end
            if (a == 8'h20) m_en = d[2:0];
        end
    endtask

    task automatic cyc(input logic we, input logic [31:0] a, input logic [31:0] d);
        we_i = we;
        addr_i = a;
        data_i = d;
        @(posedge clk);
        model_step(we, a[7:0], d);
        @(negedge clk);
        check("duty1", 32'(duty_o_1), m_cur[0]);
        check("duty2", 32'(duty_o_2), m_cur[1]);
        check("duty3", 32'(duty_o_3), m_cur[2]);
        check("done", 32'(done_o), 32'(m_done));
        check("rdata", data_o, m_read(a[7:0]));
        we_i = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 32'h24, 0);
    endtask

    task automatic to_tick();
        for (int k = 0; k < 2 * TC && (ncyc % TC) != TC - 1; k++) cyc(0, 32'h24, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 0;
        #1;
        model_reset();
        check("rst_duty1", 32'(duty_o_1), 0);
        check("rst_duty2", 32'(duty_o_2), 0);
        check("rst_duty3", 32'(duty_o_3), 0);
        check("rst_done", 32'(done_o), 0);
        @(negedge clk);
        @(negedge clk);
        check("rst_hold1", 32'(duty_o_1), 0);
        rst = 1;
    endtask

    logic [9:0] seq [$];
    logic [9:0] last;
    int         npulse;
    logic [7:0] amap [15] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h20,
                              8'h24, 8'h30, 8'h34, 8'h38, 8'h3C, 8'h40, 8'hFF};

    initial begin
        model_reset();
        do_reset();

        // up-ramp 0 -> 10 by 3
        cyc(1, 32'h00, 10);
        cyc(1, 32'h10, 3);
        cyc(1, 32'h20, 1);
        seq.delete();
        last = duty_o_1;
        npulse = 0;
        for (int k = 0; k < 24; k++) begin
            idle(1);
            if (duty_o_1 != last) seq.push_back(duty_o_1);
            last = duty_o_1;
            if (done_o[0]) npulse++;
        end
        check("up_len", seq.size(), 4);
        if (seq.size() == 4) begin
            check("up_s0", 32'(seq[0]), 3);
            check("up_s1", 32'(seq[1]), 6);
            check("up_s2", 32'(seq[2]), 9);
            check("up_s3", 32'(seq[3]), 10);
        end
        check("up_pulses", npulse, 1);
        check("up_busy", {31'b0, data_o[0]}, 0);

        // down-ramp with target clamp
        cyc(1, 32'h04, 10);
        cyc(1, 32'h20, 32'h100);
        check("dn_cur2", 32'(duty_o_2), 10);
        cyc(1, 32'h04, 1200);
        check("dn_clamp", data_o, 999);
        cyc(1, 32'h04, 2);
        cyc(1, 32'h14, 5);
        cyc(1, 32'h20, 2);
        seq.delete();
        last = duty_o_2;
        npulse = 0;
        for (int k = 0; k < 20; k++) begin
            idle(1);
            if (duty_o_2 != last) seq.push_back(duty_o_2);
            last = duty_o_2;
            if (done_o[1]) npulse++;
        end
        check("dn_len", seq.size(), 2);
        if (seq.size() == 2) begin
            check("dn_s0", 32'(seq[0]), 5);
            check("dn_s1", 32'(seq[1]), 2);
        end
        check("dn_pulses", npulse, 1);

        // jump with STEP=0, then immediate load
        cyc(1, 32'h18, 0);
        cyc(1, 32'h08, 500);
        cyc(1, 32'h20, 4);
        npulse = 0;
        for (int k = 0; k < 8; k++) begin
            idle(1);
            if (done_o[2]) npulse++;
        end
        check("jump_val", 32'(duty_o_3), 500);
        check("jump_pulse", npulse, 1);
        cyc(1, 32'h08, 100);
        cyc(1, 32'h20, 32'h104);
        check("load_val", 32'(duty_o_3), 100);
        check("load_nodone", 32'(done_o), 0);
        cyc(0, 32'h20, 0);
        check("ctrl_b8_rd0", {31'b0, data_o[8]}, 0);

        // TARGET write colliding with a tick
        cyc(1, 32'h20, 0);
        cyc(1, 32'h10, 2);
        cyc(1, 32'h00, 20);
        cyc(1, 32'h20, 1);
        to_tick();
        cyc(1, 32'h00, 4);
        check("coll_old", 32'(duty_o_1), 12);
        to_tick();
        idle(1);
        check("coll_new", 32'(duty_o_1), 10);

        // disable mid-ramp, then resume
        cyc(1, 32'h20, 0);
        cyc(1, 32'h00, 0);
        cyc(1, 32'h20, 32'h100);
        cyc(1, 32'h00, 10);
        cyc(1, 32'h10, 3);
        cyc(1, 32'h20, 1);
        for (int k = 0; k < 20 && m_cur[0] != 6; k++) idle(1);
        check("dis_reach6", 32'(duty_o_1), 6);
        cyc(1, 32'h20, 0);
        idle(10);
        check("dis_hold", 32'(duty_o_1), 6);
        check("dis_busy", {31'b0, data_o[0]}, 0);
        cyc(1, 32'h20, 1);
        to_tick();
        idle(1);
        check("dis_resume", 32'(duty_o_1), 9);

        // reset mid-ramp
        cyc(1, 32'h00, 900);
        cyc(1, 32'h10, 7);
        cyc(1, 32'h20, 7);
        idle(10);
        do_reset();
        for (int k = 0; k < 15; k++) begin
            cyc(0, {24'h0, amap[k]}, 0);
            check("rst_reg", data_o, 0);
        end

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            logic [31:0] ad, d;
            ad = {$urandom, amap[$urandom_range(0, 14)]} & 32'hFFFF_FFFF;
            ad[7:0] = amap[$urandom_range(0, 14)];
            case ($urandom_range(0, 3))
                0: d = $urandom_range(0, 1100);
                1: d = $urandom_range(0, 40);
                2: d = {23'b0, ($urandom_range(0, 9) == 0), 5'b0, 3'($urandom)};
                default: d = $urandom;
            endcase
            if (k == 800) do_reset();
            cyc($urandom_range(0, 5) == 0, ad, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
